// File: rtl/int_exec_stage_pkg.sv
// int_exec_stage_pkg: shared ALU op codes, operand select encodings, state encodings and the result entry
package int_exec_stage_pkg;
  localparam int DATA_W = 32;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic SEL_A_RS1 = 1'b0;
  localparam logic SEL_A_PC  = 1'b1;
  localparam logic SEL_B_RS2 = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_e;
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [4:0]        rd;
    logic              we;
    logic              br_taken;
    logic [DATA_W-1:0] br_target;
  } entry_t;
endpackage

// File: rtl/int_exec_stage_alu.sv
// int_alu: combinational integer ALU; unknown op codes produce zero
module int_alu
  import int_exec_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);
  // result select by opcode; comparisons return 0/1 in bit 0
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SLL:  y_o = a_i << b_i[4:0];
      ALU_SRL:  y_o = a_i >> b_i[4:0];
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      ALU_EQ:   y_o = {{(XLEN-1){1'b0}}, a_i == b_i};
      default:  y_o = '0;
    endcase
  end
endmodule

// File: rtl/int_exec_stage.sv
// int_exec_stage: integer execute stage (operand mux, ALU, branch resolve, output register); INT_EXEC_SKID_EN adds a 2-entry skid buffer
module int_exec_stage
  import int_exec_stage_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC_TGT = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alu_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_sel_a,
  input  logic            in_sel_b,
  input  logic [4:0]      in_rd,
  input  logic            in_is_br,
  input  logic            in_br_inv,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_br_taken,
  output logic [XLEN-1:0] out_br_target
);
  logic [XLEN-1:0] op_a, op_b, alu_y;
  entry_t new_e, head_q, head_d;
  state_e state_q, state_d;
  logic accept, drain;
  assign op_a = (!in_is_br && in_sel_a == SEL_A_PC) ? in_pc : in_rs1;
  assign op_b = (!in_is_br && in_sel_b == SEL_B_IMM) ? in_imm : in_rs2;
  int_alu #(.XLEN(XLEN)) u_alu (.op_i(in_alu_op), .a_i(op_a), .b_i(op_b), .y_o(alu_y));
  assign new_e = '{result: alu_y, rd: in_rd, we: !in_is_br && in_rd != 5'd0,
                   br_taken: in_is_br && (alu_y[0] ^ in_br_inv), br_target: in_pc + in_imm};
  assign out_valid     = state_q != ST_EMPTY;
  assign drain         = out_valid && out_ready;
  assign accept        = in_valid && in_ready;
  assign out_result    = head_q.result;
  assign out_rd        = head_q.rd;
  assign out_we        = head_q.we;
  assign out_br_taken  = out_valid && head_q.br_taken;
  assign out_br_target = head_q.br_target;
`ifdef INT_EXEC_SKID_EN
  entry_t tail_q, tail_d;
  logic rdy_q;
  assign in_ready = rdy_q && !rst;
  // two-entry FIFO: head drives the outputs, tail catches an op arriving while head is stalled
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) state_d = ST_EMPTY;
    else if (state_q == ST_EMPTY) begin
      if (accept) begin
        state_d = ST_ONE;
        head_d  = new_e;
      end
    end else if (state_q == ST_ONE) begin
      if (accept && drain) head_d = new_e;
      else if (accept) begin
        state_d = ST_TWO;
        tail_d  = new_e;
      end else if (drain) state_d = ST_EMPTY;
    end else if (drain) begin
      state_d = ST_ONE;
      head_d  = tail_q;
    end
  end
  // state, entries and registered ready (ready depends only on occupancy)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
      head_q  <= '{result: '0, rd: '0, we: 1'b0, br_taken: 1'b0, br_target: RESET_PC_TGT};
      tail_q  <= '{result: '0, rd: '0, we: 1'b0, br_taken: 1'b0, br_target: RESET_PC_TGT};
    end else begin
      state_q <= state_d;
      rdy_q   <= state_d != ST_TWO;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end
`else
  assign in_ready = !rst && (!out_valid || out_ready);
  // single output register: load on accept, empty on flush or drain without refill
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    if (flush) state_d = ST_EMPTY;
    else if (accept) begin
      state_d = ST_ONE;
      head_d  = new_e;
    end else if (drain) state_d = ST_EMPTY;
  end
  // state and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '{result: '0, rd: '0, we: 1'b0, br_taken: 1'b0, br_target: RESET_PC_TGT};
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
    end
  end
`endif
endmodule

// File: tb/tb_int_exec_stage.sv
// tb_int_exec_stage: randomized self-checking bench for int_exec_stage against a queue-based reference model
module tb_int_exec_stage;
`ifdef INT_EXEC_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  logic clk = 0;
  logic rst, in_valid, in_ready, in_sel_a, in_sel_b, in_is_br, in_br_inv, flush;
  logic out_valid, out_ready, out_we, out_br_taken;
  logic [3:0] in_alu_op;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc, out_result, out_br_target;
  logic [4:0] in_rd, out_rd;
  typedef struct {logic [31:0] result; logic [4:0] rd; logic we; logic br; logic [31:0] tgt;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, drains = 0;

  int_exec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc), .in_sel_a(in_sel_a),
    .in_sel_b(in_sel_b), .in_rd(in_rd), .in_is_br(in_is_br), .in_br_inv(in_br_inv), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_we(out_we), .out_br_taken(out_br_taken), .out_br_target(out_br_target)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_op();
    exp_t e;
    logic [31:0] a, b, r;
    a = (in_sel_a && !in_is_br) ? in_pc : in_rs1;
    b = (in_sel_b && !in_is_br) ? in_imm : in_rs2;
    case (in_alu_op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $unsigned($signed(a) >>> b[4:0]);
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = (a == b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    e.result = r;
    e.rd = in_rd;
    e.we = !in_is_br && (in_rd != 0);
    e.br = in_is_br && (r[0] != in_br_inv);
    e.tgt = in_pc + in_imm;
    return e;
  endfunction

  task automatic set_op(input logic [3:0] op, input logic [31:0] rs1, rs2, imm, pc,
                        input logic sa, sb, input logic [4:0] rd, input logic br, inv);
    in_alu_op = op; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc;
    in_sel_a = sa; in_sel_b = sb; in_rd = rd; in_is_br = br; in_br_inv = inv;
  endtask

  task automatic rand_op();
    set_op(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
           $urandom, $urandom, 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
  endtask

  // called at a negedge with inputs already driven; checks, advances the model, returns at the next negedge
  task automatic cycle();
    logic exp_rdy, acc, drn, exp_br;
    #1;
    exp_rdy = rst ? 1'b0 : ((CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready));
    vectors++;
    if (out_valid !== (q.size() > 0)) begin
      miscompares++; $display("FAIL out_valid: got %b want %b", out_valid, q.size() > 0);
    end
    vectors++;
    if (in_ready !== exp_rdy) begin
      miscompares++; $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy);
    end
    exp_br = (q.size() > 0) ? q[0].br : 1'b0;
    vectors++;
    if (out_br_taken !== exp_br) begin
      miscompares++; $display("FAIL out_br_taken: got %b want %b", out_br_taken, exp_br);
    end
    if (q.size() > 0) begin
      vectors++;
      if (out_result !== q[0].result || out_rd !== q[0].rd || out_we !== q[0].we) begin
        miscompares++;
        $display("FAIL out_fields: got res=%h rd=%0d we=%b want res=%h rd=%0d we=%b",
                 out_result, out_rd, out_we, q[0].result, q[0].rd, q[0].we);
      end
      if (q[0].br) begin
        vectors++;
        if (out_br_target !== q[0].tgt) begin
          miscompares++; $display("FAIL out_br_target: got %h want %h", out_br_target, q[0].tgt);
        end
      end
    end
    acc = in_valid && exp_rdy;
    drn = (q.size() > 0) && out_ready && !rst;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (drn) begin
        void'(q.pop_front());
        drains++;
      end
      if (flush) q.delete();
      else if (acc) q.push_back(ref_op());
    end
    @(negedge clk);
  endtask

  task automatic idle_drain(input int n);
    in_valid = 0; flush = 0; out_ready = 1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; flush = 0; out_ready = 1;
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 0 || out_result !== 0 || out_rd !== 0 || out_we !== 0 || out_br_taken !== 0 || out_br_target !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_values: got v=%b res=%h rd=%0d we=%b br=%b tgt=%h want all zero",
               out_valid, out_result, out_rd, out_we, out_br_taken, out_br_target);
    end
    in_valid = 1;
    cycle();
    rst = 0; in_valid = 0;
    cycle();
  endtask

  task automatic test_directed();
    in_valid = 1; out_ready = 1; flush = 0;
    set_op(4'd0, 5, 7, 0, 0, 0, 0, 3, 0, 0);
    cycle();
    vectors++;
    if (out_valid !== 1 || out_result !== 12 || out_rd !== 3 || out_we !== 1) begin
      miscompares++;
      $display("FAIL add_5_7: got v=%b res=%0d rd=%0d we=%b want 1 12 3 1", out_valid, out_result, out_rd, out_we);
    end
    set_op(4'd8, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 1, 1, 9, 1, 0);
    cycle();
    vectors++;
    if (out_br_taken !== 1 || out_br_target !== 32'h120 || out_we !== 0) begin
      miscompares++;
      $display("FAIL blt: got br=%b tgt=%h we=%b want 1 120 0", out_br_taken, out_br_target, out_we);
    end
    set_op(4'd8, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 0, 0, 9, 1, 1);
    cycle();
    vectors++;
    if (out_br_taken !== 0 || out_we !== 0) begin
      miscompares++; $display("FAIL bge: got br=%b we=%b want 0 0", out_br_taken, out_we);
    end
    set_op(4'd9, 32'hFFFF_FFFF, 1, 32'h8, 32'hFFFF_FFFC, 0, 0, 0, 1, 1);
    cycle();
    vectors++;
    if (out_br_taken !== 1 || out_br_target !== 32'h4) begin
      miscompares++; $display("FAIL bgeu_wrap: got br=%b tgt=%h want 1 4", out_br_taken, out_br_target);
    end
    set_op(4'd0, 5, 7, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    vectors++;
    if (out_we !== 0 || out_result !== 12) begin
      miscompares++; $display("FAIL add_rd0: got we=%b res=%0d want 0 12", out_we, out_result);
    end
    set_op(4'd14, 3, 4, 0, 0, 0, 0, 6, 0, 0);
    cycle();
    vectors++;
    if (out_result !== 0 || out_we !== 1) begin
      miscompares++; $display("FAIL unknown_op: got res=%h we=%b want 0 1", out_result, out_we);
    end
    idle_drain(2);
  endtask

  task automatic test_backpressure();
    in_valid = 1; out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      rand_op();
      cycle();
    end
    #1;
    vectors++;
    if (in_ready !== 0 || out_valid !== 1) begin
      miscompares++; $display("FAIL stall_ready: got rdy=%b v=%b want 0 1", in_ready, out_valid);
    end
    @(negedge clk);
    idle_drain(4);
    vectors++;
    if (out_valid !== 0) begin
      miscompares++; $display("FAIL stall_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    out_ready = 1; flush = 0; in_valid = 1;
    d0 = drains;
    for (int i = 0; i < 8; i++) begin
      set_op(4'd0, 32'(100 * i), 0, 32'(i), 0, 0, 1, 5'(i + 1), 0, 0);
      cycle();
    end
    idle_drain(1);
    vectors++;
    if (drains - d0 !== 8) begin
      miscompares++; $display("FAIL back_to_back: got %0d results want 8", drains - d0);
    end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1;
    rand_op();
    cycle();
    flush = 1;
    set_op(4'd0, 32'hDEAD, 0, 0, 0, 0, 0, 7, 0, 0);
    cycle();
    vectors++;
    if (out_valid !== 0) begin
      miscompares++; $display("FAIL flush_full: got v=%b want 0", out_valid);
    end
    idle_drain(3);
  endtask

  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      rand_op();
      cycle();
    end
    rst = 1;
    cycle();
    vectors++;
    if (out_valid !== 0 || out_result !== 0 || out_rd !== 0 || out_we !== 0 || out_br_taken !== 0 || out_br_target !== 0) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%b res=%h rd=%0d we=%b br=%b tgt=%h want all zero",
               out_valid, out_result, out_rd, out_we, out_br_taken, out_br_target);
    end
    rst = 0;
    idle_drain(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 24) == 0);
      rst = 1'($urandom_range(0, 79) == 0);
      rand_op();
      cycle();
    end
    rst = 0;
    idle_drain(3);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
